// File: rtl/and_or_selftest_if.sv
// Signal bundle between the AND-OR self-test controller and its user / block under test.
// Directions are named from the self-test side: _i into the controller, _o out of it.
interface and_or_selftest_if #(
    parameter int ERR_W = 8
);
    logic             start_i;
    logic             f_i;
    logic             a_o;
    logic             b_o;
    logic             c_o;
    logic             d_o;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic [ERR_W-1:0] err_count_o;
    logic [3:0]       first_fail_vec_o;
    logic             first_fail_vld_o;

    modport slave (
        input  start_i, f_i,
        output a_o, b_o, c_o, d_o, busy_o, done_o, pass_o,
               err_count_o, first_fail_vec_o, first_fail_vld_o
    );

    modport master (
        output start_i, f_i,
        input  a_o, b_o, c_o, d_o, busy_o, done_o, pass_o,
               err_count_o, first_fail_vec_o, first_fail_vld_o
    );
endinterface

// File: rtl/and_or_selftest.sv
// Built-in self-test for the registered AND-OR block f=(a&b)|(c&d): sweeps all 16
// input vectors REPEAT times and checks f after LATENCY cycles against the expected value.
module and_or_selftest #(
    parameter int LATENCY = 1,
    parameter int REPEAT  = 1,
    parameter int ERR_W   = 8
) (
    input logic              clk,
    input logic              rst_n,
    and_or_selftest_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] LAST_SWEEP = 8'(REPEAT - 1);
    localparam logic [3:0] LAST_DRN   = 4'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [3:0]       stim_q, stim_d;
    logic [7:0]       sweep_q, sweep_d;
    logic [3:0]       drn_q, drn_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       ffv_q, ffv_d;
    logic             ffvld_q, ffvld_d;
    logic             mismatch;

    // Check pipeline: entry [0] holds the vector driven in the previous cycle,
    // entry [LATENCY-1] is the one whose response is on f_i now.
    logic [LATENCY-1:0]      vld_pipe;
    logic [LATENCY-1:0]      exp_pipe;
    logic [LATENCY-1:0][3:0] vec_pipe;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        sweep_d = sweep_q;
        drn_d   = drn_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvld_d = ffvld_q;

        mismatch = vld_pipe[LATENCY-1] && (bus.f_i != exp_pipe[LATENCY-1]);
        if (mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (!ffvld_q) begin
                ffv_d   = vec_pipe[LATENCY-1];
                ffvld_d = 1'b1;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    vec_d   = 4'h0;
                    sweep_d = 8'h0;
                    err_d   = '0;
                    ffv_d   = 4'h0;
                    ffvld_d = 1'b0;
                end
            end
            RUN: begin
                if (vec_q == 4'hF) begin
                    vec_d = 4'h0;
                    if (sweep_q == LAST_SWEEP) begin
                        state_d = DRAIN;
                        drn_d   = 4'h0;
                    end else begin
                        sweep_d = sweep_q + 8'd1;
                    end
                end else begin
                    vec_d = vec_q + 4'd1;
                end
            end
            default: begin
                // DRAIN: wait for the last responses to come back
                if (drn_q == LAST_DRN) state_d = DONE;
                else                   drn_d   = drn_q + 4'd1;
            end
        endcase

        stim_d = (state_d == RUN) ? vec_d : 4'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= 4'h0;
            stim_q   <= 4'h0;
            sweep_q  <= 8'h0;
            drn_q    <= 4'h0;
            err_q    <= '0;
            ffv_q    <= 4'h0;
            ffvld_q  <= 1'b0;
            vld_pipe <= '0;
            exp_pipe <= '0;
            vec_pipe <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            stim_q  <= stim_d;
            sweep_q <= sweep_d;
            drn_q   <= drn_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvld_q <= ffvld_d;
            for (int i = LATENCY - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
                vec_pipe[i] <= vec_pipe[i-1];
            end
            vld_pipe[0] <= (state_q == RUN);
            exp_pipe[0] <= (vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]);
            vec_pipe[0] <= vec_q;
        end
    end

    assign bus.a_o              = stim_q[3];
    assign bus.b_o              = stim_q[2];
    assign bus.c_o              = stim_q[1];
    assign bus.d_o              = stim_q[0];
    assign bus.busy_o           = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done_o           = (state_q == DONE);
    assign bus.pass_o           = (state_q == DONE) && (err_q == '0);
    assign bus.err_count_o      = err_q;
    assign bus.first_fail_vec_o = ffv_q;
    assign bus.first_fail_vld_o = ffvld_q;
endmodule

// File: tb/tb_and_or_selftest.sv
// Bench for and_or_selftest: four controller instances with different LATENCY/REPEAT/ERR_W,
// each driving a behavioural AND-OR block with selectable delay, tie-off or per-vector faults.
module tb_and_or_selftest;
    localparam int NI = 4;
    localparam logic [NI-1:0][3:0] LAT = {4'd1, 4'd1, 4'd2, 4'd1};
    localparam logic [NI-1:0][7:0] REP = {8'd2, 8'd2, 8'd1, 8'd1};
    localparam logic [NI-1:0][3:0] EW  = {4'd3, 4'd8, 4'd8, 4'd8};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_r[NI];
    logic [1:0]  mode[NI];   // 0: function ^ mask, 1: tied 0, 2: tied 1
    logic [15:0] mask[NI];
    logic [1:0]  dsel[NI];   // block delay minus one

    logic       busy_w[NI], done_w[NI], pass_w[NI], ffvld_w[NI];
    logic [3:0] stim_w[NI], ffvec_w[NI];
    logic [7:0] err_w[NI];

    int n_chk = 0;
    int n_fail = 0;

    for (genvar g = 0; g < NI; g++) begin : gi
        and_or_selftest_if #(.ERR_W(int'(EW[g]))) ifc ();
        logic [3:0] v;
        logic       fraw;
        logic [3:0] sh = 4'h0;
        assign v    = {ifc.a_o, ifc.b_o, ifc.c_o, ifc.d_o};
        assign fraw = (mode[g] == 2'd1) ? 1'b0 :
                      (mode[g] == 2'd2) ? 1'b1 :
                      (((v[3] & v[2]) | (v[1] & v[0])) ^ mask[g][v]);
        always @(posedge clk) sh <= {sh[2:0], fraw};
        assign ifc.f_i     = sh[dsel[g]];
        assign ifc.start_i = start_r[g];

        and_or_selftest #(.LATENCY(int'(LAT[g])), .REPEAT(int'(REP[g])), .ERR_W(int'(EW[g]))) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (ifc.slave)
        );

        assign busy_w[g]  = ifc.busy_o;
        assign done_w[g]  = ifc.done_o;
        assign pass_w[g]  = ifc.pass_o;
        assign ffvld_w[g] = ifc.first_fail_vld_o;
        assign ffvec_w[g] = ifc.first_fail_vec_o;
        assign stim_w[g]  = v;
        assign err_w[g]   = 8'(ifc.err_count_o);
    end

    // Reference: outcome of one test from the block's per-vector behaviour.
    function automatic void model(input int md, input logic [15:0] msk, input int rep, input int ew,
                                  output int errs, output int ff, output bit ffv);
        int n = 0;
        int fexp, fgot;
        ff = 0; ffv = 0;
        for (int v = 0; v < 16; v++) begin
            fexp = ((v / 8) % 2 & (v / 4) % 2) | ((v / 2) % 2 & v % 2);
            fgot = (md == 1) ? 0 : (md == 2) ? 1 : (fexp ^ int'(msk[v]));
            if (fgot != fexp) begin
                n++;
                if (!ffv) begin ffv = 1; ff = v; end
            end
        end
        errs = n * rep;
        if (errs > (1 << ew) - 1) errs = (1 << ew) - 1;
    endfunction

    task automatic setup(input int g, input logic [1:0] md, input logic [15:0] msk, input int dly);
        mode[g] = md; mask[g] = msk; dsel[g] = 2'(dly - 1);
    endtask

    // Pulse start, then count busy cycles and vectors that differ from the expected sweep order.
    task automatic run_one(input int g, output int bcyc, output int stim_bad);
        int e;
        @(negedge clk) start_r[g] = 1'b1;
        @(negedge clk) start_r[g] = 1'b0;
        bcyc = 0; stim_bad = 0;
        while (busy_w[g] && bcyc < 2000) begin
            e = (bcyc < 16 * int'(REP[g])) ? bcyc % 16 : 0;
            if (stim_w[g] !== 4'(e)) stim_bad++;
            bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        for (int g = 0; g < NI; g++) begin
            n_chk++;
            if ({busy_w[g], done_w[g], pass_w[g], ffvld_w[g], stim_w[g], ffvec_w[g], err_w[g]} !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_outputs inst %0d got b%0d d%0d p%0d v%0d s%0d f%0d e%0d want all 0", g,
                         busy_w[g], done_w[g], pass_w[g], ffvld_w[g], stim_w[g], ffvec_w[g], err_w[g]);
            end
        end
    endtask

    task automatic test_correct;
        int b, sb;
        setup(0, 2'd0, 16'h0, 1);
        run_one(0, b, sb);
        n_chk++; if (b !== 17) begin n_fail++; $display("FAIL correct_busy got %0d want 17", b); end
        n_chk++; if (sb !== 0) begin n_fail++; $display("FAIL correct_stim_order got %0d bad want 0", sb); end
        n_chk++; if (done_w[0] !== 1'b1) begin n_fail++; $display("FAIL correct_done got %0d want 1", done_w[0]); end
        n_chk++; if (pass_w[0] !== 1'b1) begin n_fail++; $display("FAIL correct_pass got %0d want 1", pass_w[0]); end
        n_chk++; if (err_w[0] !== 8'd0) begin n_fail++; $display("FAIL correct_err got %0d want 0", err_w[0]); end
        n_chk++; if (ffvld_w[0] !== 1'b0) begin n_fail++; $display("FAIL correct_ffvld got %0d want 0", ffvld_w[0]); end
        setup(1, 2'd0, 16'h0, 2);
        run_one(1, b, sb);
        n_chk++; if (b !== 18) begin n_fail++; $display("FAIL lat2_busy got %0d want 18", b); end
        n_chk++; if (pass_w[1] !== 1'b1) begin n_fail++; $display("FAIL lat2_pass got %0d want 1", pass_w[1]); end
    endtask

    task automatic test_tie;
        int b, sb;
        setup(0, 2'd1, 16'h0, 1);
        run_one(0, b, sb);
        n_chk++; if (err_w[0] !== 8'd7) begin n_fail++; $display("FAIL tie0_err got %0d want 7", err_w[0]); end
        n_chk++; if (ffvec_w[0] !== 4'b0011) begin n_fail++; $display("FAIL tie0_ffvec got %0d want 3", ffvec_w[0]); end
        n_chk++; if (ffvld_w[0] !== 1'b1) begin n_fail++; $display("FAIL tie0_ffvld got %0d want 1", ffvld_w[0]); end
        n_chk++; if (pass_w[0] !== 1'b0) begin n_fail++; $display("FAIL tie0_pass got %0d want 0", pass_w[0]); end
        setup(0, 2'd2, 16'h0, 1);
        run_one(0, b, sb);
        n_chk++; if (err_w[0] !== 8'd9) begin n_fail++; $display("FAIL tie1_err got %0d want 9", err_w[0]); end
        n_chk++; if (ffvec_w[0] !== 4'b0000) begin n_fail++; $display("FAIL tie1_ffvec got %0d want 0", ffvec_w[0]); end
        n_chk++; if (pass_w[0] !== 1'b0) begin n_fail++; $display("FAIL tie1_pass got %0d want 0", pass_w[0]); end
        setup(2, 2'd1, 16'h0, 1);
        run_one(2, b, sb);
        n_chk++; if (b !== 33) begin n_fail++; $display("FAIL rep2_busy got %0d want 33", b); end
        n_chk++; if (sb !== 0) begin n_fail++; $display("FAIL rep2_stim_order got %0d bad want 0", sb); end
        n_chk++; if (err_w[2] !== 8'd14) begin n_fail++; $display("FAIL rep2_err got %0d want 14", err_w[2]); end
        setup(3, 2'd1, 16'h0, 1);
        run_one(3, b, sb);
        n_chk++; if (err_w[3] !== 8'd7) begin n_fail++; $display("FAIL sat_err got %0d want 7", err_w[3]); end
    endtask

    task automatic test_latency_mismatch;
        int b, sb;
        setup(0, 2'd0, 16'h0, 2);
        run_one(0, b, sb);
        n_chk++; if (done_w[0] !== 1'b1) begin n_fail++; $display("FAIL latmis_done got %0d want 1", done_w[0]); end
        n_chk++; if (pass_w[0] !== 1'b0) begin n_fail++; $display("FAIL latmis_pass got %0d want 0", pass_w[0]); end
        setup(0, 2'd0, 16'h0, 1);
    endtask

    task automatic test_random;
        int b, sb, g, errs, ff;
        bit ffv;
        logic [1:0] md;
        logic [15:0] msk;
        for (int it = 0; it < 12; it++) begin
            g   = $urandom_range(0, NI - 1);
            md  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            msk = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            setup(g, md, msk, int'(LAT[g]));
            model(int'(md), msk, int'(REP[g]), int'(EW[g]), errs, ff, ffv);
            run_one(g, b, sb);
            n_chk++; if (b !== 16 * int'(REP[g]) + int'(LAT[g])) begin n_fail++; $display("FAIL rand_busy inst %0d got %0d want %0d", g, b, 16 * int'(REP[g]) + int'(LAT[g])); end
            n_chk++; if (err_w[g] !== 8'(errs)) begin n_fail++; $display("FAIL rand_err inst %0d mask %h got %0d want %0d", g, msk, err_w[g], errs); end
            n_chk++; if (ffvld_w[g] !== ffv) begin n_fail++; $display("FAIL rand_ffvld inst %0d got %0d want %0d", g, ffvld_w[g], ffv); end
            n_chk++; if (pass_w[g] !== !ffv) begin n_fail++; $display("FAIL rand_pass inst %0d got %0d want %0d", g, pass_w[g], !ffv); end
            if (ffv) begin
                n_chk++; if (ffvec_w[g] !== 4'(ff)) begin n_fail++; $display("FAIL rand_ffvec inst %0d got %0d want %0d", g, ffvec_w[g], ff); end
            end
        end
        setup(0, 2'd0, 16'h0, 1);
    endtask

    task automatic test_back_to_back;
        int b;
        // start while busy is ignored
        setup(0, 2'd0, 16'h0, 1);
        @(negedge clk) start_r[0] = 1'b1;
        @(negedge clk) start_r[0] = 1'b0;
        b = 0;
        while (busy_w[0] && b < 200) begin
            start_r[0] = (b == 5);
            b++;
            @(negedge clk);
        end
        start_r[0] = 1'b0;
        n_chk++; if (b !== 17) begin n_fail++; $display("FAIL busy_start_busy got %0d want 17", b); end
        n_chk++; if (pass_w[0] !== 1'b1) begin n_fail++; $display("FAIL busy_start_pass got %0d want 1", pass_w[0]); end
        // restart from DONE
        repeat (3) @(negedge clk);
        start_r[0] = 1'b1;
        @(negedge clk) start_r[0] = 1'b0;
        n_chk++; if ({done_w[0], busy_w[0]} !== 2'b01) begin n_fail++; $display("FAIL restart_done_busy got %b want 01", {done_w[0], busy_w[0]}); end
        b = 0;
        while (busy_w[0] && b < 200) begin b++; @(negedge clk); end
        n_chk++; if (b !== 17) begin n_fail++; $display("FAIL restart_busy got %0d want 17", b); end
        n_chk++; if (pass_w[0] !== 1'b1) begin n_fail++; $display("FAIL restart_pass got %0d want 1", pass_w[0]); end
    endtask

    task automatic test_reset_mid;
        int b, sb;
        setup(0, 2'd1, 16'h0, 1);
        @(negedge clk) start_r[0] = 1'b1;
        @(negedge clk) start_r[0] = 1'b0;
        b = 0;
        while (stim_w[0] !== 4'd7 && b < 40) begin b++; @(negedge clk); end
        n_chk++; if (stim_w[0] !== 4'd7) begin n_fail++; $display("FAIL mid_reach_vec7 got %0d want 7", stim_w[0]); end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy_w[0], done_w[0], pass_w[0], ffvld_w[0], stim_w[0], ffvec_w[0], err_w[0]} !== 19'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got b%0d d%0d p%0d v%0d s%0d f%0d e%0d want all 0",
                     busy_w[0], done_w[0], pass_w[0], ffvld_w[0], stim_w[0], ffvec_w[0], err_w[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_chk++; if (done_w[0] !== 1'b0) begin n_fail++; $display("FAIL mid_no_done got %0d want 0", done_w[0]); end
        setup(0, 2'd0, 16'h0, 1);
        run_one(0, b, sb);
        n_chk++; if (b !== 17) begin n_fail++; $display("FAIL post_reset_busy got %0d want 17", b); end
        n_chk++; if (pass_w[0] !== 1'b1) begin n_fail++; $display("FAIL post_reset_pass got %0d want 1", pass_w[0]); end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            start_r[g] = 1'b0; mode[g] = 2'd0; mask[g] = 16'h0; dsel[g] = 2'(int'(LAT[g]) - 1);
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_correct();
        test_tie();
        test_latency_mismatch();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
